bus_arbiter: RTL and testbench

//  Two-requester arbiter for the shared 16-bit operand bus fed by the 2:1 mux.

---
 rtl/bus_arbiter_if.sv | 32 +++
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Request/data/grant bundle shared by two bus masters and the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bus_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req_a;
  logic [WIDTH-1:0] a_data;
  logic             req_b;
  logic [WIDTH-1:0] b_data;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;

  modport slave (
    input  req_a, a_data, req_b, b_data,
    output gnt_a, gnt_b, sel, bus_out, bus_valid
  );

  modport master (
    output req_a, a_data, req_b, b_data,
    input  gnt_a, gnt_b, sel, bus_out, bus_valid
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-requester round-robin arbiter with hold limit; drives the 2:1
//            mux select and registers the selected data onto bus_out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  bus_arbiter_if.slave    bus
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;       // 0 = A granted most recently, 1 = B
  logic             last_nxt;
  logic [CW-1:0]    hold_cnt;
  logic [CW-1:0]    hold_nxt;
  logic             gnt_a;
  logic             gnt_b;
  logic             take;
  logic [WIDTH-1:0] bus_out_r;
  logic             bus_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold_cnt;

    unique case (state)
      IDLE: begin
        if (bus.req_a && !bus.req_b)
          state_nxt = GNT_A;
        else if (bus.req_b && !bus.req_a)
          state_nxt = GNT_B;
        else if (bus.req_a && bus.req_b)
          state_nxt = last ? GNT_A : GNT_B;
      end
      GNT_A: begin
        if (!bus.req_a)
          state_nxt = bus.req_b ? GNT_B : IDLE;
        else if (bus.req_b && (hold_cnt == HOLD_LIMIT))
          state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!bus.req_b)
          state_nxt = bus.req_a ? GNT_A : IDLE;
        else if (bus.req_a && (hold_cnt == HOLD_LIMIT))
          state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase

    // The hold counter only advances while the other side is waiting.
    if (state_nxt != state) begin
      hold_nxt = '0;
      if (state_nxt == GNT_A)
        last_nxt = 1'b0;
      else if (state_nxt == GNT_B)
        last_nxt = 1'b1;
    end else if (((state == GNT_A) && bus.req_b) || ((state == GNT_B) && bus.req_a)) begin
      if (hold_cnt != HOLD_LIMIT)
        hold_nxt = hold_cnt + 1'b1;
    end
  end

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);
  assign take  = (gnt_a && bus.req_a) || (gnt_b && bus.req_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid_r <= 1'b0;
      bus_out_r   <= '0;
    end else begin
      bus_valid_r <= take;
      if (take)
        bus_out_r <= gnt_b ? bus.b_data : bus.a_data;
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.sel       = gnt_b;
  assign bus.bus_out   = bus_out_r;
  assign bus.bus_valid = bus_valid_r;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  bus_arbiter_if #(.WIDTH(16)) bif ();

  bus_arbiter #(.WIDTH(16), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_a;
    logic [15:0] exp_d;

    bif.req_a  = 1'b1;
    bif.req_b  = 1'b1;
    bif.a_data = 16'h1111;
    bif.b_data = 16'h2222;

    // Reset held with both requests asserted
    tick();
    tick();
    chk("rst_gnt_a", 32'(bif.gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(bif.gnt_b), 32'd0);
    chk("rst_sel", 32'(bif.sel), 32'd0);
    chk("rst_bus_out", 32'(bif.bus_out), 32'd0);
    chk("rst_valid", 32'(bif.bus_valid), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("first_gnt_a", 32'(bif.gnt_a), 32'd1);
    chk("first_gnt_b", 32'(bif.gnt_b), 32'd0);
    chk("first_valid", 32'(bif.bus_valid), 32'd0);

    // Single requester A
    bif.req_b  = 1'b0;
    bif.a_data = 16'h00FF;
    tick();
    chk("single_gnt_a", 32'(bif.gnt_a), 32'd1);
    chk("single_sel", 32'(bif.sel), 32'd0);
    chk("single_bus_out", 32'(bif.bus_out), 32'h00FF);
    chk("single_valid", 32'(bif.bus_valid), 32'd1);

    // Handover A -> B with no idle cycle
    bif.req_b  = 1'b1;
    bif.b_data = 16'h0002;
    bif.req_a  = 1'b0;
    tick();
    chk("hand_gnt_b", 32'(bif.gnt_b), 32'd1);
    chk("hand_gnt_a", 32'(bif.gnt_a), 32'd0);
    chk("hand_sel", 32'(bif.sel), 32'd1);
    chk("hand_valid0", 32'(bif.bus_valid), 32'd0);
    chk("hand_hold_out", 32'(bif.bus_out), 32'h00FF);
    tick();
    chk("hand_bus_out", 32'(bif.bus_out), 32'h0002);
    chk("hand_valid1", 32'(bif.bus_valid), 32'd1);

    // Release: B drops, arbiter returns to idle
    bif.req_b = 1'b0;
    tick();
    chk("rel_gnt_b", 32'(bif.gnt_b), 32'd0);
    chk("rel_gnt_a", 32'(bif.gnt_a), 32'd0);
    chk("rel_valid", 32'(bif.bus_valid), 32'd0);

    // Round-robin from idle: last winner was B, so A then B
    bif.req_a = 1'b1;
    bif.req_b = 1'b1;
    tick();
    chk("rr1_gnt_a", 32'(bif.gnt_a), 32'd1);
    bif.req_a = 1'b0;
    bif.req_b = 1'b0;
    tick();
    chk("rr_idle1", 32'({bif.gnt_a, bif.gnt_b}), 32'd0);
    bif.req_a = 1'b1;
    bif.req_b = 1'b1;
    tick();
    chk("rr2_gnt_b", 32'(bif.gnt_b), 32'd1);
    chk("rr2_gnt_a", 32'(bif.gnt_a), 32'd0);
    bif.req_a = 1'b0;
    bif.req_b = 1'b0;
    tick();
    chk("rr_idle2", 32'({bif.gnt_a, bif.gnt_b}), 32'd0);

    // Preemption under sustained contention: 8-cycle alternation, A first
    bif.a_data = 16'hAAAA;
    bif.b_data = 16'hBBBB;
    bif.req_a  = 1'b1;
    bif.req_b  = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      exp_a = (((i / 8) % 2) == 0);
      chk($sformatf("pre_gnt_a[%0d]", i), 32'(bif.gnt_a), 32'(exp_a));
      chk($sformatf("pre_gnt_b[%0d]", i), 32'(bif.gnt_b), 32'(!exp_a));
      chk($sformatf("pre_onehot[%0d]", i), 32'(bif.gnt_a & bif.gnt_b), 32'd0);
      if (i == 0) begin
        chk("pre_valid0", 32'(bif.bus_valid), 32'd0);
      end else begin
        exp_d = ((((i - 1) / 8) % 2) == 0) ? 16'hAAAA : 16'hBBBB;
        chk($sformatf("pre_valid[%0d]", i), 32'(bif.bus_valid), 32'd1);
        chk($sformatf("pre_bus_out[%0d]", i), 32'(bif.bus_out), 32'(exp_d));
      end
    end

    // Async reset in the middle of a B grant, between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_b", 32'(bif.gnt_b), 32'd0);
    chk("ar_gnt_a", 32'(bif.gnt_a), 32'd0);
    chk("ar_sel", 32'(bif.sel), 32'd0);
    chk("ar_valid", 32'(bif.bus_valid), 32'd0);
    chk("ar_bus_out", 32'(bif.bus_out), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_regrant_a", 32'(bif.gnt_a), 32'd1);
    chk("ar_regrant_b", 32'(bif.gnt_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
